// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receive path.
// Contents:
//   - parity mode encodings for par_mode (PAR_NONE, PAR_EVEN, PAR_ODD; 2'b11 behaves as none)
//   - receiver FSM state type
//   - helpers that give the bit positions of the error flags inside a FIFO entry
//     {brk, ferr, perr, data[dbit-1:0]}
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  // Entry layout: data occupies [dbit-1:0], flags sit directly above it.
  function automatic int unsigned ent_perr(input int unsigned dbit);
    return dbit;
  endfunction

  function automatic int unsigned ent_ferr(input int unsigned dbit);
    return dbit + 1;
  endfunction

  function automatic int unsigned ent_brk(input int unsigned dbit);
    return dbit + 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received UART words.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (storage cleared to 0)
//   wr, w_data : write request and word
//   rd         : pop request for the head word
//   r_data     : head word, read combinationally from storage
//   full, empty, level : occupancy status, level exact from 0 to 2**FIFO_W
//   drop       : a write was refused because the FIFO was full and not popped
// A write while full succeeds when a pop happens in the same cycle; a pop
// while empty is ignored.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH  = 11,
  parameter int unsigned FIFO_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [WIDTH-1:0]  w_data,
  input  logic              rd,
  output logic [WIDTH-1:0]  r_data,
  output logic              full,
  output logic              empty,
  output logic [FIFO_W:0]   level,
  output logic              drop
);

  localparam int unsigned Depth = 2 ** FIFO_W;
  localparam int unsigned DepthBits = Depth;
  localparam logic [FIFO_W:0] LvlFull = DepthBits[FIFO_W:0];

  logic [WIDTH-1:0]  mem_q [Depth];
  logic [FIFO_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_W:0]   level_q, level_d;
  logic              do_wr, do_rd;

  assign full   = (level_q == LvlFull);
  assign empty  = (level_q == '0);
  assign level  = level_q;
  assign r_data = mem_q[rd_ptr_q];

  assign do_rd = rd & ~empty;
  // The simultaneous pop frees the slot the write needs.
  assign do_wr = wr & (~full | do_rd);
  assign drop  = wr & ~do_wr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_wr && !do_rd) level_d = level_q + 1'b1;
    else if (!do_wr && do_rd) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (do_wr) mem_q[wr_ptr_q] <= w_data;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_cfg.sv
// Configurable UART receiver with error-flagged FWFT receive FIFO.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   rx            : asynchronous serial input, idle high
//   par_mode      : 00 none, 01 even, 10 odd, 11 none; latched at frame start
//   rd_uart       : pop head word; clr_ovr : clear sticky overrun
//   rd_data, rd_perr, rd_ferr, rd_brk : head word and its error flags
//   rx_empty, rx_full, fifo_level     : FIFO status
//   overrun       : sticky, a received word was dropped
//   rx_busy       : receiver FSM not idle
// Build option: define UART_RX_MAJORITY_EN to take every start/data/parity/stop
// decision as a 2-of-3 vote over the decision tick and the two ticks before it.
module uart_rx_fifo_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned OS         = 16,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned DVSR       = 326,
  parameter int unsigned DVSR_WIDTH = 9,
  parameter int unsigned FIFO_W     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  input  logic [1:0]        par_mode,
  input  logic              rd_uart,
  input  logic              clr_ovr,
  output logic [DBIT-1:0]   rd_data,
  output logic              rd_perr,
  output logic              rd_ferr,
  output logic              rd_brk,
  output logic              rx_empty,
  output logic              rx_full,
  output logic [FIFO_W:0]   fifo_level,
  output logic              overrun,
  output logic              rx_busy
);

  localparam int unsigned EW      = DBIT + 3;
  localparam int unsigned EntPerr = ent_perr(DBIT);
  localparam int unsigned EntFerr = ent_ferr(DBIT);
  localparam int unsigned EntBrk  = ent_brk(DBIT);
  localparam int unsigned SMax    = (SB_TICK > OS) ? SB_TICK : OS;
  localparam int unsigned SW      = $clog2(SMax);
  localparam int unsigned NW      = $clog2(DBIT);

  localparam logic [DVSR_WIDTH-1:0] BaudLast = DVSR_WIDTH'(DVSR - 1);
  localparam logic [SW-1:0] SStartMid = SW'(OS / 2 - 1);
  localparam logic [SW-1:0] SBitEnd   = SW'(OS - 1);
  localparam logic [SW-1:0] SStopEnd  = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] NLast     = NW'(DBIT - 1);

  // Input synchroniser, resets to the idle level.
  logic rx_meta_q, rx_s;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s      <= rx_meta_q;
    end
  end

  // Free-running oversampling tick generator.
  logic [DVSR_WIDTH-1:0] baud_q;
  logic                  s_tick;
  assign s_tick = (baud_q == BaudLast);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) baud_q <= '0;
    else        baud_q <= s_tick ? '0 : baud_q + 1'b1;
  end

  // Value used for each bit decision.
  logic sample;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      hist_q <= 2'b11;
    else if (s_tick) hist_q <= {hist_q[0], rx_s};
  end
  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  rx_state_e       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] data_q, data_d;
  logic [1:0]      par_q, par_d;
  logic            pbit_q, pbit_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            par_on;
  logic            rx_done;
  logic [EW-1:0]   entry;

  assign par_on = (par_q == PAR_EVEN) || (par_q == PAR_ODD);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    data_d  = data_q;
    par_d   = par_q;
    pbit_d  = pbit_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    rx_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          s_d     = '0;
          par_d   = par_mode;
          pbit_d  = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      StStart: begin
        if (s_tick) begin
          if (s_q == SStartMid) begin
            if (!sample) begin
              state_d = StData;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (s_q == SBitEnd) begin
            s_d    = '0;
            data_d = {sample, data_q[DBIT-1:1]};
            if (n_q == NLast) state_d = par_on ? StParity : StStop;
            else              n_d     = n_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (s_tick) begin
          if (s_q == SBitEnd) begin
            s_d     = '0;
            pbit_d  = sample;
            perr_d  = (par_q == PAR_ODD) ? ~(^data_q ^ sample) : (^data_q ^ sample);
            state_d = StStop;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (s_tick) begin
          if (s_q == SBitEnd) ferr_d = ~sample;
          // With one stop bit the sample and the end coincide, so use ferr_d.
          if (s_q == SStopEnd) begin
            rx_done = 1'b1;
            state_d = StIdle;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    entry               = '0;
    entry[DBIT-1:0]     = data_q;
    entry[EntPerr]      = par_on & perr_q;
    entry[EntFerr]      = ferr_d;
    entry[EntBrk]       = ferr_d & (data_q == '0) & (~par_on | ~pbit_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      data_q  <= '0;
      par_q   <= PAR_NONE;
      pbit_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      data_q  <= data_d;
      par_q   <= par_d;
      pbit_q  <= pbit_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  logic [EW-1:0] head;
  logic          drop;

  uart_rx_fifo #(
    .WIDTH  (EW),
    .FIFO_W (FIFO_W)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr     (rx_done),
    .w_data (entry),
    .rd     (rd_uart),
    .r_data (head),
    .full   (rx_full),
    .empty  (rx_empty),
    .level  (fifo_level),
    .drop   (drop)
  );

  assign rd_data = head[DBIT-1:0];
  assign rd_perr = head[EntPerr];
  assign rd_ferr = head[EntFerr];
  assign rd_brk  = head[EntBrk];
  assign rx_busy = (state_q != StIdle);

  // A new drop wins over a clear in the same cycle.
  logic overrun_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overrun_q <= 1'b0;
    else if (drop)    overrun_q <= 1'b1;
    else if (clr_ovr) overrun_q <= 1'b0;
  end
  assign overrun = overrun_q;

endmodule
